// File: rtl/dma_csr_if.sv
// ---------------------------------------------------------------------------
// dma_csr_if
// Avalon-style CSR bus with wait-request, shared by the host-side master and
// the DMA register file.
//   csr_wr_i       write request, held until csr_wait_rq_o drops
//   csr_rd_i       read request, held until csr_wait_rq_o drops
//   csr_addr_i     byte address
//   csr_wr_data_i  write data
//   csr_be_i       write byte enables
//   csr_wait_rq_o  high while the transfer is not complete
//   csr_rd_data_o  read data, valid when reading and csr_wait_rq_o is low
// ---------------------------------------------------------------------------
interface dma_csr_if #(
    parameter int ADDR_W = 8
) ();
    logic              csr_wr_i;
    logic              csr_rd_i;
    logic [ADDR_W-1:0] csr_addr_i;
    logic [31:0]       csr_wr_data_i;
    logic [3:0]        csr_be_i;
    logic              csr_wait_rq_o;
    logic [31:0]       csr_rd_data_o;

    modport master (
        output csr_wr_i, csr_rd_i, csr_addr_i, csr_wr_data_i, csr_be_i,
        input  csr_wait_rq_o, csr_rd_data_o
    );

    modport slave (
        input  csr_wr_i, csr_rd_i, csr_addr_i, csr_wr_data_i, csr_be_i,
        output csr_wait_rq_o, csr_rd_data_o
    );
endinterface

// File: rtl/dma_csr_mc.sv
// ---------------------------------------------------------------------------
// dma_csr_mc
// Multi-channel DMA control/status register file behind one wait-request
// slave port. Each channel has CONTROL (GO self-clearing, IRQ_EN, storage),
// STATUS (BUSY mirror, sticky W1C DONE/ERR), DESC_PTR (word aligned) and a
// reserved word. Address 0xF0 returns the per-channel interrupt pending map.
// Ports:
//   clk            clock, rising edge
//   reset_n        synchronous active-low reset
//   csr            dma_csr_if slave modport (host bus)
//   ch_busy_i      per-channel busy level
//   ch_done_i      per-channel done pulse
//   ch_err_i       per-channel error pulse
//   ch_go_o        one-cycle launch pulse per channel
//   ch_ctrl_o      CONTROL registers, channel c at [32c+31:32c], GO reads 0
//   ch_desc_ptr_o  DESC_PTR registers, same packing
//   irq_o          registered interrupt level
// ---------------------------------------------------------------------------
module dma_csr_mc #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dma_csr_if.slave             csr,
    input  logic [NUM_CH-1:0]    ch_busy_i,
    input  logic [NUM_CH-1:0]    ch_done_i,
    input  logic [NUM_CH-1:0]    ch_err_i,
    output logic [NUM_CH-1:0]    ch_go_o,
    output logic [NUM_CH*32-1:0] ch_ctrl_o,
    output logic [NUM_CH*32-1:0] ch_desc_ptr_o,
    output logic                 irq_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_ACK  = 2'd1,
        RD_WAIT = 2'd2,
        RD_ACK  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr;
    logic [3:0]        ch_idx;
    logic [1:0]        reg_sel;
    logic              irq_hit;
    logic              wr_commit;
    logic              addr_unused;

    logic [31:0]       ctrl_all [NUM_CH];
    logic [31:0]       desc_all [NUM_CH];
    logic [NUM_CH-1:0] done_all;
    logic [NUM_CH-1:0] err_all;
    logic [NUM_CH-1:0] irq_en_all;
    logic [NUM_CH-1:0] pend;
    logic [31:0]       rd_mux;
    logic [31:0]       rd_data_p1;
    logic              irq_p1;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign addr        = csr.csr_addr_i;
    assign ch_idx      = addr[7:4];
    assign reg_sel     = addr[3:2];
    assign irq_hit     = (addr[7:2] == 6'h3C);
    assign addr_unused = &{1'b0, addr[1:0]};
    assign wr_commit   = (state == WR_ACK);

    // ---- transfer FSM ----
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (csr.csr_wr_i)      state_nxt = WR_ACK;
                else if (csr.csr_rd_i) state_nxt = RD_WAIT;
                else                   state_nxt = IDLE;
            end
            WR_ACK:  state_nxt = IDLE;
            RD_WAIT: state_nxt = RD_ACK;
            RD_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign csr.csr_wait_rq_o = !((state == WR_ACK) || (state == RD_ACK));

    // ---- per-channel register banks ----
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic        sel, wr_ctrl, wr_stat, wr_desc, go_req;
        logic [31:0] ctrl_q, desc_q;
        logic        done_q, err_q, go_q;

        assign sel     = wr_commit && (ch_idx == 4'(c));
        assign wr_ctrl = sel && (reg_sel == 2'd0);
        assign wr_stat = sel && (reg_sel == 2'd1) && csr.csr_be_i[0];
        assign wr_desc = sel && (reg_sel == 2'd2);
        assign go_req  = wr_ctrl && csr.csr_be_i[0] && csr.csr_wr_data_i[0];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                ctrl_q <= '0;
                desc_q <= '0;
                done_q <= 1'b0;
                err_q  <= 1'b0;
                go_q   <= 1'b0;
            end else begin
                // GO is never stored; it only produces the launch pulse.
                if (wr_ctrl)
                    ctrl_q <= be_merge(ctrl_q, csr.csr_wr_data_i, csr.csr_be_i)
                              & 32'hFFFF_FFFE;
                if (wr_desc)
                    desc_q <= be_merge(desc_q, csr.csr_wr_data_i, csr.csr_be_i)
                              & 32'hFFFF_FFFC;
                go_q <= go_req && !ch_busy_i[c];
                // Hardware set terms are OR-ed last so they win over W1C.
                done_q <= ch_done_i[c]
                          | (done_q & ~(wr_stat & csr.csr_wr_data_i[1]));
                err_q  <= ch_err_i[c] | (go_req & ch_busy_i[c])
                          | (err_q & ~(wr_stat & csr.csr_wr_data_i[2]));
            end
        end

        assign ctrl_all[c]               = ctrl_q;
        assign desc_all[c]               = desc_q;
        assign done_all[c]               = done_q;
        assign err_all[c]                = err_q;
        assign irq_en_all[c]             = ctrl_q[1];
        assign ch_go_o[c]                = go_q;
        assign ch_ctrl_o[32*c +: 32]     = ctrl_q;
        assign ch_desc_ptr_o[32*c +: 32] = desc_q;
    end

    assign pend = (done_all | err_all) & irq_en_all;

    // ---- read path ----
    always_comb begin
        rd_mux = '0;
        if (irq_hit) begin
            rd_mux = {{(32-NUM_CH){1'b0}}, pend};
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 4'(c)) begin
                    case (reg_sel)
                        2'd0:    rd_mux = ctrl_all[c];
                        2'd1:    rd_mux = {29'd0, err_all[c], done_all[c], ch_busy_i[c]};
                        2'd2:    rd_mux = desc_all[c];
                        default: rd_mux = '0;
                    endcase
                end
            end
        end
    end

    // ---- stage p1: read data capture and interrupt level ----
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_p1 <= '0;
            irq_p1     <= 1'b0;
        end else begin
            if (state == RD_WAIT) rd_data_p1 <= rd_mux;
            irq_p1 <= |pend;
        end
    end

    assign csr.csr_rd_data_o = rd_data_p1;
    assign irq_o             = irq_p1;

endmodule

// File: tb/tb_dma_csr_mc.sv
// ---------------------------------------------------------------------------
// tb_dma_csr_mc
// Directed self-checking bench for dma_csr_mc with NUM_CH=4.
// ---------------------------------------------------------------------------
module tb_dma_csr_mc;
    localparam int NUM_CH = 4;

    logic                 clk;
    logic                 reset_n;
    logic [NUM_CH-1:0]    ch_busy, ch_done, ch_err, ch_go;
    logic [NUM_CH*32-1:0] ch_ctrl, ch_desc;
    logic                 irq;
    logic [31:0]          rd;
    int                   n_cmp;
    int                   n_fail;

    dma_csr_if #(.ADDR_W(8)) bus ();

    dma_csr_mc #(.NUM_CH(NUM_CH), .ADDR_W(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .csr           (bus),
        .ch_busy_i     (ch_busy),
        .ch_done_i     (ch_done),
        .ch_err_i      (ch_err),
        .ch_go_o       (ch_go),
        .ch_ctrl_o     (ch_ctrl),
        .ch_desc_ptr_o (ch_desc),
        .irq_o         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.csr_addr_i    = a;
        bus.csr_wr_data_i = d;
        bus.csr_be_i      = be;
        bus.csr_wr_i      = 1'b1;
        tick();
        chk("wr_wait_cycle1", bus.csr_wait_rq_o, 1'b0);
        tick();
        bus.csr_wr_i = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d);
        bus.csr_addr_i = a;
        bus.csr_rd_i   = 1'b1;
        tick();
        chk("rd_wait_cycle1", bus.csr_wait_rq_o, 1'b1);
        tick();
        chk("rd_wait_cycle2", bus.csr_wait_rq_o, 1'b0);
        d = bus.csr_rd_data_o;
        bus.csr_rd_i = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset_n           = 1'b0;
        bus.csr_wr_i      = 1'b0;
        bus.csr_rd_i      = 1'b0;
        bus.csr_addr_i    = '0;
        bus.csr_wr_data_i = '0;
        bus.csr_be_i      = '0;
        ch_busy = '0;
        ch_done = '0;
        ch_err  = '0;

        // Reset with idle inputs
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_wait", bus.csr_wait_rq_o, 1'b1);
        chk("rst_rdata", bus.csr_rd_data_o, 32'h0);
        chk("rst_irq", irq, 1'b0);
        chk("rst_go", ch_go, 4'h0);
        ch_busy = 4'b0010;
        do_read(8'h14, rd); chk("rst_status1_busy", rd, 32'h1);
        do_read(8'h00, rd); chk("rst_ctrl0", rd, 32'h0);
        do_read(8'h08, rd); chk("rst_desc0", rd, 32'h0);
        do_read(8'hF0, rd); chk("rst_irqpend", rd, 32'h0);
        ch_busy = 4'b0000;

        // Byte-enabled DESC_PTR write with alignment
        chk("wr_wait_cycle0", bus.csr_wait_rq_o, 1'b1);
        do_write(8'h18, 32'hDEADBEEF, 4'b0101);
        chk("desc1_port", ch_desc[63:32], 32'h00AD00EC);
        do_read(8'h18, rd); chk("desc1_read", rd, 32'h00AD00EC);

        // GO when idle: one-cycle pulse, CONTROL reads back without GO
        do_write(8'h00, 32'h3, 4'b0001);
        chk("go_pulse", ch_go, 4'b0001);
        tick();
        chk("go_pulse_end", ch_go, 4'b0000);
        do_read(8'h00, rd); chk("ctrl0_read", rd, 32'h2);
        chk("ctrl0_port", ch_ctrl[31:0], 32'h2);

        // GO while busy: dropped, ERR set, interrupt raised (IRQ_EN=1)
        ch_busy = 4'b0001;
        do_write(8'h00, 32'h3, 4'b0001);
        chk("go_busy_none", ch_go, 4'b0000);
        tick();
        chk("go_busy_none2", ch_go, 4'b0000);
        do_read(8'h04, rd); chk("status0_busy_err", rd, 32'h5);
        chk("irq_from_err", irq, 1'b1);
        ch_busy = 4'b0000;
        do_write(8'h04, 32'h4, 4'b0001);
        tick();
        chk("irq_err_cleared", irq, 1'b0);
        do_read(8'h04, rd); chk("status0_cleared", rd, 32'h0);

        // DONE -> irq two edges later
        do_write(8'h20, 32'h2, 4'b1111);
        ch_done = 4'b0100;
        tick();
        ch_done = 4'b0000;
        chk("irq_edge1", irq, 1'b0);
        tick();
        chk("irq_edge2", irq, 1'b1);
        do_read(8'hF0, rd); chk("irqpend", rd, 32'h4);
        do_read(8'h24, rd); chk("status2_done", rd, 32'h2);

        // W1C DONE; irq falls one cycle after commit
        do_write(8'h24, 32'h2, 4'b0001);
        chk("irq_at_commit", irq, 1'b1);
        tick();
        chk("irq_after_commit", irq, 1'b0);
        do_read(8'h24, rd); chk("status2_w1c", rd, 32'h0);

        // W1C without byte enable 0 has no effect
        ch_done = 4'b0100;
        tick();
        ch_done = 4'b0000;
        do_write(8'h24, 32'h2, 4'b1110);
        do_read(8'h24, rd); chk("status2_no_be0", rd, 32'h2);

        // Done pulse on the commit edge wins over W1C
        bus.csr_addr_i    = 8'h24;
        bus.csr_wr_data_i = 32'h2;
        bus.csr_be_i      = 4'b0001;
        bus.csr_wr_i      = 1'b1;
        tick();
        ch_done = 4'b0100;
        tick();
        ch_done = 4'b0000;
        bus.csr_wr_i = 1'b0;
        do_read(8'h24, rd); chk("status2_set_wins", rd, 32'h2);
        do_write(8'h24, 32'h2, 4'b0001);
        tick();
        chk("irq_final_clear", irq, 1'b0);

        // Unmapped channel and reserved word
        do_write(8'h50, 32'hFFFFFFFF, 4'b1111);
        do_write(8'h0C, 32'hFFFFFFFF, 4'b1111);
        do_write(8'hF0, 32'hFFFFFFFF, 4'b1111);
        do_read(8'h50, rd); chk("unmapped_read", rd, 32'h0);
        do_read(8'h0C, rd); chk("reserved_read", rd, 32'h0);
        do_read(8'hF0, rd); chk("irqpend_ro", rd, 32'h0);
        chk("ctrl_unchanged", ch_ctrl, 128'h00000000_00000002_00000000_00000002);
        chk("desc_unchanged", ch_desc, 128'h00000000_00000000_00AD00EC_00000000);

        // Simultaneous write and read: only the write happens
        bus.csr_addr_i    = 8'h38;
        bus.csr_wr_data_i = 32'h12345678;
        bus.csr_be_i      = 4'b1111;
        bus.csr_wr_i      = 1'b1;
        bus.csr_rd_i      = 1'b1;
        tick();
        chk("both_wait_low", bus.csr_wait_rq_o, 1'b0);
        tick();
        bus.csr_wr_i = 1'b0;
        bus.csr_rd_i = 1'b0;
        chk("both_desc3", ch_desc[127:96], 32'h12345678);
        tick();
        chk("both_no_read_wait", bus.csr_wait_rq_o, 1'b1);
        tick();
        chk("both_rdata_kept", bus.csr_rd_data_o, 32'h0);
        do_read(8'h38, rd); chk("desc3_read", rd, 32'h12345678);

        // Reset during RD_WAIT
        ch_done = 4'b0010;
        tick();
        ch_done = 4'b0000;
        bus.csr_addr_i = 8'h38;
        bus.csr_rd_i   = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        bus.csr_rd_i = 1'b0;
        reset_n      = 1'b1;
        chk("rrst_wait", bus.csr_wait_rq_o, 1'b1);
        chk("rrst_rdata", bus.csr_rd_data_o, 32'h0);
        chk("rrst_ctrl", ch_ctrl, 128'h0);
        chk("rrst_desc", ch_desc, 128'h0);
        chk("rrst_irq", irq, 1'b0);
        tick();
        chk("rrst_idle_wait", bus.csr_wait_rq_o, 1'b1);
        do_read(8'h14, rd); chk("rrst_status1", rd, 32'h0);
        do_read(8'h38, rd); chk("rrst_desc3", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
